// File: rtl/kernel_buffer_ctrl.sv
// kernel_buffer_ctrl
// Double-buffered kernel store for the Conv2d engine. One bank holds every
// input-channel kernel of the current filter. The next filter streams in
// from AXI-Stream into the other bank at the same time.
//
// Ports
//   clk, Reset                  clock; synchronous active-low reset
//   cfg_ch_size                 channels per filter (1..DEPTH), latched when a load is accepted
//   load_start / load_ready     start a load into the free bank / writer can accept one
//   load_done                   one-cycle pulse the cycle after the final beat
//   s_axis_t{data,valid,last}   kernel word stream
//   s_axis_tready               stream ready
//   keep_mode                   1: wrap reads on the same bank instead of releasing it
//   rd_next / rd_release        read the next channel word / free the read bank
//   buf_ready                   read bank is full
//   rd_data/rd_valid/rd_last_ch registered read port (1-cycle latency)
//   err_tlast                   sticky: tlast did not match the final beat
module kernel_buffer_ctrl #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 512,
  parameter int CH_W   = 9
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [CH_W:0]     cfg_ch_size,
  input  logic              load_start,
  output logic              load_ready,
  output logic              load_done,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              keep_mode,
  input  logic              rd_next,
  input  logic              rd_release,
  output logic              buf_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last_ch,
  output logic              err_tlast
);

  localparam logic [CH_W:0] ONE = 1;

  typedef enum logic {W_IDLE, W_LOAD} wstate_e;

  wstate_e                 wstate_q;
  logic [1:0]              full_q, full_d;
  logic                    w_sel_q, r_sel_q;
  logic [1:0][CH_W:0]      ch_size_q;
  logic [CH_W-1:0]         waddr_q, raddr_q, raddr_d;
  logic                    load_done_q, err_q;
  logic                    rd_valid_q, rd_last_q;
  logic [DATA_W-1:0]       rd_data_q;

  // Bank index is the MSB of the memory address.
  logic [DATA_W-1:0]       mem [2*DEPTH];

  logic wbeat, wis_last, wfinal;
  logic rel, rd, ris_last, rpop;

  assign s_axis_tready = (wstate_q == W_LOAD);
  assign load_ready    = (wstate_q == W_IDLE) & ~full_q[w_sel_q];
  assign buf_ready     = full_q[r_sel_q];

  assign wbeat    = (wstate_q == W_LOAD) & s_axis_tvalid;
  assign wis_last = ({1'b0, waddr_q} == (ch_size_q[w_sel_q] - ONE));
  assign wfinal   = wbeat & wis_last;

  // Release beats a same-cycle read; the read is dropped.
  assign rel      = rd_release & buf_ready;
  assign rd       = rd_next & buf_ready & ~rd_release;
  assign ris_last = ({1'b0, raddr_q} == (ch_size_q[r_sel_q] - ONE));
  assign rpop     = rel | (rd & ris_last & ~keep_mode);

  // Writer sets and reader clears always hit different banks: the writer
  // only fills an empty bank, the reader only frees a full one.
  always_comb begin
    full_d = full_q;
    if (rpop)   full_d[r_sel_q] = 1'b0;
    if (wfinal) full_d[w_sel_q] = 1'b1;
  end

  always_comb begin
    raddr_d = raddr_q;
    if (rel)     raddr_d = '0;
    else if (rd) raddr_d = ris_last ? '0 : raddr_q + 1'b1;
  end

  // Writer FSM
  always_ff @(posedge clk) begin
    if (!Reset) begin
      wstate_q    <= W_IDLE;
      w_sel_q     <= 1'b0;
      waddr_q     <= '0;
      ch_size_q   <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      load_done_q <= wfinal;
      case (wstate_q)
        W_IDLE: begin
          if (load_start && load_ready) begin
            ch_size_q[w_sel_q] <= cfg_ch_size;
            waddr_q            <= '0;
            wstate_q           <= W_LOAD;
          end
        end
        W_LOAD: begin
          if (wbeat) begin
            waddr_q <= waddr_q + 1'b1;
            // Length comes from the count; tlast is only cross-checked.
            if (s_axis_tlast != wis_last) err_q <= 1'b1;
            if (wis_last) begin
              w_sel_q  <= ~w_sel_q;
              wstate_q <= W_IDLE;
            end
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Bank bookkeeping and read port
  always_ff @(posedge clk) begin
    if (!Reset) begin
      full_q     <= '0;
      r_sel_q    <= 1'b0;
      raddr_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      raddr_q    <= raddr_d;
      if (rpop) r_sel_q <= ~r_sel_q;
      rd_valid_q <= rd;
      rd_last_q  <= rd & ris_last;
      if (rd) rd_data_q <= mem[{r_sel_q, raddr_q}];
    end
  end

  always_ff @(posedge clk) begin
    if (wbeat) mem[{w_sel_q, waddr_q}] <= s_axis_tdata;
  end

  assign load_done  = load_done_q;
  assign err_tlast  = err_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last_ch = rd_last_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_kernel_buffer_ctrl.sv
// Randomized bench for kernel_buffer_ctrl. The reference model treats the
// two banks as a FIFO of at most two completed filters, stored as one flat
// word queue plus a queue of filter sizes; the reader walks the front filter.
module tb_kernel_buffer_ctrl;
  localparam int DATA_W = 72;
  localparam int DEPTH  = 512;
  localparam int CH_W   = 9;

  logic              clk = 1'b0;
  logic              Reset;
  logic [CH_W:0]     cfg_ch_size;
  logic              load_start, load_ready, load_done;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic              keep_mode, rd_next, rd_release, buf_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last_ch, err_tlast;

  kernel_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .clk(clk), .Reset(Reset), .cfg_ch_size(cfg_ch_size),
    .load_start(load_start), .load_ready(load_ready), .load_done(load_done),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .keep_mode(keep_mode), .rd_next(rd_next), .rd_release(rd_release),
    .buf_ready(buf_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last_ch(rd_last_ch), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] words[$];   // completed filters, front filter first
  int                sizes[$];
  int                rpos;
  bit                loading;
  int                lsize;
  logic [DATA_W-1:0] lbuf[$];
  bit                e_done, e_err, e_rv, e_last;
  logic [DATA_W-1:0] e_rd;

  task automatic m_reset();
    words.delete(); sizes.delete(); lbuf.delete();
    rpos = 0; loading = 0; lsize = 0;
    e_done = 0; e_err = 0; e_rv = 0; e_last = 0; e_rd = '0;
  endtask

  task automatic m_pop();
    for (int i = 0; i < sizes[0]; i++) void'(words.pop_front());
    void'(sizes.pop_front());
  endtask

  // One clock edge of the model, using the inputs driven this cycle.
  task automatic m_step();
    bit ld_rdy, have;
    int n0;
    if (!Reset) begin
      m_reset();
      return;
    end
    ld_rdy = !loading && sizes.size() < 2;
    have   = sizes.size() > 0;
    n0     = have ? sizes[0] : 0;
    e_done = 0; e_rv = 0; e_last = 0;
    if (have && rd_release) begin
      m_pop();
      rpos = 0;
    end else if (have && rd_next) begin
      e_rv   = 1;
      e_rd   = words[rpos];
      e_last = (rpos == n0 - 1);
      if (e_last) begin
        rpos = 0;
        if (!keep_mode) m_pop();
      end else rpos++;
    end
    if (loading) begin
      if (s_axis_tvalid) begin
        if (s_axis_tlast != (lbuf.size() == lsize - 1)) e_err = 1;
        lbuf.push_back(s_axis_tdata);
        if (lbuf.size() == lsize) begin
          foreach (lbuf[i]) words.push_back(lbuf[i]);
          sizes.push_back(lsize);
          lbuf.delete();
          loading = 0;
          e_done  = 1;
        end
      end
    end else if (load_start && ld_rdy) begin
      loading = 1;
      lsize   = int'(cfg_ch_size);
      lbuf.delete();
    end
  endtask

  task automatic check_outputs();
    chk("load_ready",    DATA_W'(load_ready),    DATA_W'(!loading && sizes.size() < 2));
    chk("s_axis_tready", DATA_W'(s_axis_tready), DATA_W'(loading));
    chk("buf_ready",     DATA_W'(buf_ready),     DATA_W'(sizes.size() > 0));
    chk("load_done",     DATA_W'(load_done),     DATA_W'(e_done));
    chk("rd_valid",      DATA_W'(rd_valid),      DATA_W'(e_rv));
    chk("rd_last_ch",    DATA_W'(rd_last_ch & rd_valid), DATA_W'(e_last & e_rv));
    chk("rd_data",       rd_data,                e_rd);
    chk("err_tlast",     DATA_W'(err_tlast),     DATA_W'(e_err));
  endtask

  task automatic drive(input int p_rd, input int p_rel, input int p_start,
                       input int p_valid, input bit keep, input bit rst);
    logic [95:0] tmp;
    bit          good_last;
    tmp           = {$urandom(), $urandom(), $urandom()};
    Reset         = !(rst || ($urandom % 1000 == 0));
    keep_mode     = keep;
    rd_next       = ($urandom % 100) < p_rd;
    rd_release    = ($urandom % 100) < p_rel;
    load_start    = ($urandom % 100) < p_start;
    cfg_ch_size   = ($urandom % 50 == 0) ? (CH_W+1)'(DEPTH)
                                         : (CH_W+1)'(1 + $urandom % 6);
    s_axis_tvalid = ($urandom % 100) < p_valid;
    s_axis_tdata  = tmp[DATA_W-1:0];
    good_last     = loading && (lbuf.size() == lsize - 1);
    s_axis_tlast  = ($urandom % 40 == 0) ? !good_last : good_last;
  endtask

  initial begin
    int p_rd[4]    = '{70, 10, 60, 90};
    int p_rel[4]   = '{2, 1, 6, 3};
    int p_st[4]    = '{30, 60, 40, 50};
    int p_vl[4]    = '{100, 50, 80, 70};
    bit keep_p[4]  = '{0, 0, 1, 0};
    m_reset();
    drive(0, 0, 0, 0, 0, 1);
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clk);
        if (!(ph == 0 && cyc == 0)) check_outputs();
        drive(p_rd[ph], p_rel[ph], p_st[ph], p_vl[ph], keep_p[ph], cyc < 2);
        @(posedge clk);
        m_step();
      end
    end
    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
